// File: rtl/rex_pkg.sv
// Shared constants and types for the rex display path: VGA 640x480@60 timing,
// game state encodings, palette, sprite geometry and the per-frame snapshot.
// Optional macro REX_SCORE_BAR_EN adds the score field to the snapshot.
package rex_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  localparam logic [7:0] COL_SKY      = 8'hDB;
  localparam logic [7:0] COL_GROUND   = 8'h49;
  localparam logic [7:0] COL_OBS      = 8'h1C;
  localparam logic [7:0] COL_REX      = 8'h92;
  localparam logic [7:0] COL_REX_OVER = 8'hE0;
  localparam logic [7:0] COL_BAR      = 8'hFC;

  localparam int unsigned REX_W    = 20;
  localparam int unsigned REX_H    = 40;
  localparam int unsigned OBS_W    = 16;
  localparam int unsigned OBS_H    = 32;
  localparam int unsigned GROUND_H = 4;
  localparam int unsigned BAR_X0   = 8;
  localparam int unsigned BAR_Y0   = 8;
  localparam int unsigned BAR_H    = 8;

  // Game inputs frozen for the duration of one frame.
  typedef struct packed {
    logic [9:0] rex_y;
    logic       rex_duck;
    logic [9:0] obs_x;
    logic [1:0] game_state;
`ifdef REX_SCORE_BAR_EN
    logic [7:0] score;
`endif
  } snap_t;

  // Half-open interval test in 11 bits so lo+len never wraps.
  function automatic logic in_range(input logic [10:0] val,
                                    input logic [10:0] lo,
                                    input logic [10:0] len);
    return (val >= lo) && (val < lo + len);
  endfunction

endpackage

// File: rtl/rex_vga_sync.sv
// VGA 640x480 timing core: pixel-rate divider, hcount/vcount and raw
// (unregistered) sync/visible decodes for the current counter position.
// Ports: clk, rst_n in; hcount, vcount (registered); pix_en_c, hsync_c,
// vsync_c, visible_c (combinational decodes).
module rex_vga_sync
  import rex_pkg::*;
#(
  parameter int unsigned PIX_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       pix_en_c,
  output logic       hsync_c,
  output logic       vsync_c,
  output logic       visible_c
);

  logic [1:0] div;

  assign pix_en_c = (div == 2'(PIX_DIV - 1));

  // Divider and raster counters; counters advance once per pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div    <= 2'd0;
      hcount <= 10'd0;
      vcount <= 10'd0;
    end else begin
      div <= pix_en_c ? 2'd0 : div + 2'd1;
      if (pix_en_c) begin
        if (hcount == 10'(H_TOTAL - 1)) begin
          hcount <= 10'd0;
          vcount <= (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end
    end
  end

  // Raw decodes; sync pulses are active low.
  assign hsync_c   = !((hcount >= 10'(H_VISIBLE + H_FP)) &&
                       (hcount <  10'(H_VISIBLE + H_FP + H_SYNC)));
  assign vsync_c   = !((vcount >= 10'(V_VISIBLE + V_FP)) &&
                       (vcount <  10'(V_VISIBLE + V_FP + V_SYNC)));
  assign visible_c = (hcount < 10'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));

endmodule

// File: rtl/rex_vga_renderer.sv
// Rex game display: VGA timing plus object renderer. Game inputs are
// snapshotted at the last pixel of each frame so a frame never tears.
// Ports: ClkPort, Reset_n (async active low); rex_y, rex_duck, obs_x,
// game_state, score inputs; hsync, vsync, rgb, frame_tick registered outputs.
// Optional macro REX_SCORE_BAR_EN draws a score bar in rows 8..15.
module rex_vga_renderer
  import rex_pkg::*;
#(
  parameter int unsigned PIX_DIV  = 4,
  parameter int unsigned REX_X    = 80,
  parameter int unsigned GROUND_Y = 400
) (
  input  logic       ClkPort,
  input  logic       Reset_n,
  input  logic [9:0] rex_y,
  input  logic       rex_duck,
  input  logic [9:0] obs_x,
  input  logic [1:0] game_state,
  input  logic [7:0] score,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_tick
);

  logic [9:0]  hcount, vcount;
  logic        pix_en_c, hsync_c, vsync_c, visible_c;
  logic [10:0] h11_c, v11_c, rex_top_c;
  logic        frame_end_c, vblank_start_c;
  logic        rex_hit_c, obs_hit_c, ground_hit_c, bar_hit_c;
  logic [7:0]  rex_col_c, pix_col_c;
  snap_t       snap, snap_in_c;

  rex_vga_sync #(.PIX_DIV(PIX_DIV)) u_sync (
    .clk      (ClkPort),
    .rst_n    (Reset_n),
    .hcount   (hcount),
    .vcount   (vcount),
    .pix_en_c (pix_en_c),
    .hsync_c  (hsync_c),
    .vsync_c  (vsync_c),
    .visible_c(visible_c)
  );

  assign frame_end_c    = pix_en_c && (hcount == 10'(H_TOTAL - 1)) &&
                          (vcount == 10'(V_TOTAL - 1));
  assign vblank_start_c = pix_en_c && (hcount == 10'(H_TOTAL - 1)) &&
                          (vcount == 10'(V_VISIBLE - 1));

  // Snapshot payload gathered from the live inputs.
  always_comb begin
    snap_in_c            = '0;
    snap_in_c.rex_y      = rex_y;
    snap_in_c.rex_duck   = rex_duck;
    snap_in_c.obs_x      = obs_x;
    snap_in_c.game_state = game_state;
`ifdef REX_SCORE_BAR_EN
    snap_in_c.score      = score;
`endif
  end

`ifndef REX_SCORE_BAR_EN
  logic unused_score;
  assign unused_score = ^score;
`endif

  // Hit tests on the current counter position, all in 11 bits.
  assign h11_c     = 11'(hcount);
  assign v11_c     = 11'(vcount);
  assign rex_top_c = snap.rex_duck ? 11'(snap.rex_y) + 11'(REX_H / 2)
                                   : 11'(snap.rex_y);
  assign rex_hit_c = in_range(h11_c, 11'(REX_X), 11'(REX_W)) &&
                     (v11_c >= rex_top_c) &&
                     (v11_c < 11'(snap.rex_y) + 11'(REX_H));
  // Columns past 639 fall into blanking, which clips the obstacle at the edge.
  assign obs_hit_c = (snap.obs_x < 10'(H_VISIBLE)) &&
                     in_range(h11_c, 11'(snap.obs_x), 11'(OBS_W)) &&
                     in_range(v11_c, 11'(GROUND_Y - OBS_H), 11'(OBS_H));
  assign ground_hit_c = in_range(v11_c, 11'(GROUND_Y), 11'(GROUND_H));
`ifdef REX_SCORE_BAR_EN
  assign bar_hit_c = in_range(v11_c, 11'(BAR_Y0), 11'(BAR_H)) &&
                     in_range(h11_c, 11'(BAR_X0), {2'b00, snap.score, 1'b0});
`else
  assign bar_hit_c = 1'b0;
`endif

  // Rex colour by game state, then priority mux rex > obstacle > ground > bar > sky.
  always_comb begin
    rex_col_c = COL_REX;
    case (snap.game_state)
      ST_IDLE, ST_RUN, ST_PAUSE: rex_col_c = COL_REX;
      ST_OVER:                   rex_col_c = COL_REX_OVER;
      default:                   rex_col_c = COL_REX;
    endcase
    pix_col_c = COL_SKY;
    if (rex_hit_c)         pix_col_c = rex_col_c;
    else if (obs_hit_c)    pix_col_c = COL_OBS;
    else if (ground_hit_c) pix_col_c = COL_GROUND;
    else if (bar_hit_c)    pix_col_c = COL_BAR;
  end

  // Output and snapshot registers.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      rgb        <= 8'd0;
      frame_tick <= 1'b0;
      snap       <= '0;
    end else begin
      frame_tick <= vblank_start_c;
      if (pix_en_c) begin
        hsync <= hsync_c;
        vsync <= vsync_c;
        rgb   <= visible_c ? pix_col_c : 8'd0;
      end
      if (frame_end_c) snap <= snap_in_c;
    end
  end

endmodule

// File: tb/tb_rex_vga_renderer.sv
// Directed bench for rex_vga_renderer. Raster position is jumped by forcing
// the timing counters so that rows deep in the frame are reached quickly.
module tb_rex_vga_renderer;

  logic       ClkPort;
  logic       Reset_n;
  logic [9:0] rex_y;
  logic       rex_duck;
  logic [9:0] obs_x;
  logic [1:0] game_state;
  logic [7:0] score;
  logic       hsync, vsync, frame_tick;
  logic [7:0] rgb;

  logic [9:0] jh, jv;
  int checks   = 0;
  int failures = 0;
  int cnt, cnt2;

`ifdef REX_SCORE_BAR_EN
  localparam logic [7:0] BAR_EXP = 8'hFC;
`else
  localparam logic [7:0] BAR_EXP = 8'hDB;
`endif

  rex_vga_renderer dut (
    .ClkPort   (ClkPort),
    .Reset_n   (Reset_n),
    .rex_y     (rex_y),
    .rex_duck  (rex_duck),
    .obs_x     (obs_x),
    .game_state(game_state),
    .score     (score),
    .hsync     (hsync),
    .vsync     (vsync),
    .rgb       (rgb),
    .frame_tick(frame_tick)
  );

  initial ClkPort = 1'b0;
  always #5 ClkPort = ~ClkPort;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Place the raster at (h,v) with the divider restarted at 0.
  task automatic jump(input int h, input int v);
    @(negedge ClkPort);
    jh = 10'(h);
    jv = 10'(v);
    force dut.u_sync.div    = 2'd0;
    force dut.u_sync.hcount = jh;
    force dut.u_sync.vcount = jv;
    @(negedge ClkPort);
    release dut.u_sync.div;
    release dut.u_sync.hcount;
    release dut.u_sync.vcount;
  endtask

  // Pixel (h,v) is registered on the 4th edge after the jump.
  task automatic pix(input int h, input int v, input logic [7:0] exp, input string tag);
    jump(h, v);
    repeat (4) @(posedge ClkPort);
    @(negedge ClkPort);
    check(tag, 32'(rgb), 32'(exp));
  endtask

  // Pass the last pixel of the frame so current inputs get snapshotted.
  task automatic new_frame();
    jump(799, 524);
    repeat (4) @(posedge ClkPort);
    @(negedge ClkPort);
  endtask

  initial begin
    Reset_n = 1'b1; rex_y = 10'd360; rex_duck = 1'b0; obs_x = 10'd1000;
    game_state = 2'd1; score = 8'd255;
    #2 Reset_n = 1'b0;
    repeat (3) @(negedge ClkPort);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    Reset_n = 1'b1;

    // Horizontal timing from reset release.
    cnt = 0;
    while (hsync === 1'b1 && cnt < 5000) begin @(negedge ClkPort); cnt++; end
    check("hsync_first_fall", 32'(cnt), 32'd2628);
    cnt = 0;
    while (hsync === 1'b0 && cnt < 5000) begin @(negedge ClkPort); cnt++; end
    check("hsync_low", 32'(cnt), 32'd384);
    cnt2 = 0;
    while (hsync === 1'b1 && cnt2 < 5000) begin @(negedge ClkPort); cnt2++; end
    check("hsync_period", 32'(cnt + cnt2), 32'd3200);

    // Vertical sync width.
    jump(790, 489);
    cnt = 0;
    while (vsync === 1'b1 && cnt < 200) begin @(negedge ClkPort); cnt++; end
    check("vsync_fall", 32'(cnt), 32'd44);
    cnt = 0;
    while (vsync === 1'b0 && cnt < 8000) begin @(negedge ClkPort); cnt++; end
    check("vsync_low", 32'(cnt), 32'd6400);

    // frame_tick at 479 -> 480, one cycle wide.
    jump(790, 479);
    cnt = 0;
    while (frame_tick !== 1'b1 && cnt < 200) begin @(negedge ClkPort); cnt++; end
    check("tick_time", 32'(cnt), 32'd40);
    @(negedge ClkPort);
    check("tick_width", 32'(frame_tick), 32'd0);

    // Standing rex, blanking, ground, score bar.
    new_frame();
    pix(85, 380, 8'h92, "rex_stand_in");
    pix(85, 355, 8'hDB, "rex_stand_above");
    pix(99, 380, 8'h92, "rex_right_col");
    pix(100, 380, 8'hDB, "rex_past_right");
    pix(700, 380, 8'h00, "hblank");
    pix(100, 500, 8'h00, "vblank");
    pix(300, 403, 8'h49, "ground_last");
    pix(300, 404, 8'hDB, "below_ground");
    pix(517, 10, BAR_EXP, "bar_end");
    pix(518, 10, 8'hDB, "bar_past_end");

    // Ducking rex.
    rex_duck = 1'b1;
    new_frame();
    pix(85, 370, 8'hDB, "rex_duck_top");
    pix(85, 390, 8'h92, "rex_duck_low");

    // Mid-frame input change must wait for the next frame.
    rex_duck = 1'b0;
    new_frame();
    rex_y = 10'd300;
    pix(85, 310, 8'hDB, "no_tear");
    new_frame();
    pix(85, 310, 8'h92, "next_frame_pos");
    rex_y = 10'd360;

    // Obstacle at the right edge.
    obs_x = 10'd630;
    new_frame();
    pix(639, 368, 8'h1C, "obs_edge_top");
    pix(630, 399, 8'h1C, "obs_left_bot");
    pix(629, 380, 8'hDB, "obs_left_out");
    pix(639, 367, 8'hDB, "obs_above");
    pix(5, 380, 8'hDB, "obs_no_wrap");
    pix(635, 400, 8'h49, "ground_under_obs");

    // Rex overlaps obstacle.
    obs_x = 10'd90;
    new_frame();
    pix(95, 380, 8'h92, "rex_over_obs");
    pix(100, 380, 8'h1C, "obs_beside_rex");

    // Off-screen obstacle.
    obs_x = 10'd1000;
    new_frame();
    pix(3, 380, 8'hDB, "obs_off_left");
    pix(630, 380, 8'hDB, "obs_off_right");

    // Game over colour, then asynchronous reset mid-line.
    game_state = 2'd3;
    new_frame();
    pix(85, 380, 8'hE0, "rex_over");
    #1 Reset_n = 1'b0;
    #1 check("async_rgb", 32'(rgb), 32'd0);
    @(negedge ClkPort);
    Reset_n = 1'b1;
    jump(700, 490);
    repeat (4) @(posedge ClkPort);
    @(negedge ClkPort);
    check("sync_low_h", 32'(hsync), 32'd0);
    check("sync_low_v", 32'(vsync), 32'd0);
    #1 Reset_n = 1'b0;
    #1 check("async_hsync", 32'(hsync), 32'd1);
    check("async_vsync", 32'(vsync), 32'd1);
    @(negedge ClkPort);
    Reset_n = 1'b1;
    cnt = 0;
    while (hsync === 1'b1 && cnt < 5000) begin @(negedge ClkPort); cnt++; end
    check("restart_hsync", 32'(cnt), 32'd2628);
    check("restart_vsync", 32'(vsync), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
